output_sram_arbiter: RTL

Round-robin arbiter that shares the single output-SRAM write port among `NUM_BANKS` vertex accumulation banks. Each bank raises a request when its feature vector is complete. The arbiter issues a one-cycle grant and then accepts that bank's sos…eos beat burst. It converts each beat into a registered SRAM write at `node_id*ROW_BEATS + beat`, and sits between the vertex buffer banks and the output SRAM.

---
 rtl/output_sram_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/output_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : output_sram_arbiter
// Brief    : Round-robin arbiter granting the output-SRAM write port to one
//            vertex accumulation bank per sos..eos burst.
// Revision : 1.0 - initial release
// ============================================================================
module output_sram_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 16,
  parameter int NODE_ID_W = 8,
  parameter int ROW_BEATS = 4,
  parameter int ADDR_W    = NODE_ID_W + $clog2(ROW_BEATS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          bank_req,
  input  logic [NUM_BANKS-1:0]          bank_gvalid,
  input  logic [NUM_BANKS-1:0]          bank_sos,
  input  logic [NUM_BANKS-1:0]          bank_eos,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  input  logic [NUM_BANKS*NODE_ID_W-1:0] bank_node_id,
  output logic [NUM_BANKS-1:0]          bank_grant,
  output logic                          sram_wen,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  output logic                          busy,
  output logic                          overflow_err
);

  localparam int c_bank_w = $clog2(NUM_BANKS);
  localparam int c_row_w  = $clog2(ROW_BEATS);
  localparam int c_cnt_w  = c_row_w + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_grant = 2'd1;
  localparam logic [1:0] c_st_burst = 2'd2;

  localparam logic [c_bank_w:0]  c_num_banks = (c_bank_w + 1)'(NUM_BANKS);
  localparam logic [c_cnt_w-1:0] c_row_beats = c_cnt_w'(ROW_BEATS);

  logic [1:0]           r_state;
  logic [c_bank_w-1:0]  r_winner;
  logic [c_bank_w-1:0]  r_rr_ptr;
  logic [NODE_ID_W-1:0] r_node_id;
  logic [c_cnt_w-1:0]   r_beat_cnt;

  logic                 w_req_found;
  logic [c_bank_w-1:0]  w_req_pick;
  logic                 w_win_gvalid;
  logic                 w_win_sos;
  logic                 w_win_eos;
  logic [DATA_W-1:0]    w_win_data;
  logic [NODE_ID_W-1:0] w_win_node;

  // (base + off) mod NUM_BANKS; both operands are already below NUM_BANKS
  function automatic logic [c_bank_w-1:0] wrap_add(input logic [c_bank_w-1:0] base,
                                                    input logic [c_bank_w-1:0] off);
    logic [c_bank_w:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= c_num_banks) begin
      sum = sum - c_num_banks;
    end
    return sum[c_bank_w-1:0];
  endfunction

  always_comb begin
    w_req_found = 1'b0;
    w_req_pick  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!w_req_found && bank_req[wrap_add(r_rr_ptr, c_bank_w'(i))]) begin
        w_req_found = 1'b1;
        w_req_pick  = wrap_add(r_rr_ptr, c_bank_w'(i));
      end
    end
  end

  always_comb begin
    w_win_gvalid = bank_gvalid[r_winner];
    w_win_sos    = bank_sos[r_winner];
    w_win_eos    = bank_eos[r_winner];
    w_win_data   = '0;
    w_win_node   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_winner == c_bank_w'(i)) begin
        w_win_data = bank_data[i*DATA_W +: DATA_W];
        w_win_node = bank_node_id[i*NODE_ID_W +: NODE_ID_W];
      end
    end
  end

  always_comb begin
    bank_grant = '0;
    if (r_state == c_st_grant) begin
      bank_grant[r_winner] = 1'b1;
    end
  end

  assign busy = (r_state != c_st_idle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_st_idle;
      r_winner     <= '0;
      r_rr_ptr     <= '0;
      r_node_id    <= '0;
      r_beat_cnt   <= '0;
      sram_wen     <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      overflow_err <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_req_found) begin
            r_winner <= w_req_pick;
            r_state  <= c_st_grant;
          end
        end
        c_st_grant: begin
          r_rr_ptr <= wrap_add(r_winner, c_bank_w'(1));
          if (w_win_gvalid && w_win_sos) begin
            sram_wen   <= 1'b1;
            sram_addr  <= {w_win_node, {c_row_w{1'b0}}};
            sram_wdata <= w_win_data;
            r_node_id  <= w_win_node;
            r_beat_cnt <= c_cnt_w'(1);
            r_state    <= w_win_eos ? c_st_idle : c_st_burst;
          end else begin
            // Bank did not start its burst in the grant cycle; it must re-request.
            r_state <= c_st_idle;
          end
        end
        c_st_burst: begin
          if (w_win_gvalid) begin
            if (r_beat_cnt == c_row_beats) begin
              overflow_err <= 1'b1;
            end else begin
              sram_wen   <= 1'b1;
              sram_addr  <= {r_node_id, r_beat_cnt[c_row_w-1:0]};
              sram_wdata <= w_win_data;
              r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
            if (w_win_eos) begin
              r_state <= c_st_idle;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
